bit_serializer: RTL and testbench
=================================

Name: bit_serializer

Overview:
- Parallel-in/serial-out stage that sits directly upstream of the Mealy 101101 sequence detector.
- Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on x, which drives the detector's serial input.
- Supports back-to-back words with no idle gap, so the detector sees a continuous bitstream across word boundaries.

Parameters:
- WIDTH, 8: data word width in bits; legal range is WIDTH >= 2.
- MSB_FIRST, 1: 1 shifts din[WIDTH-1] out first; 0 shifts din[0] out first.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low: rst=0 immediately clears all state.
- din  in  WIDTH  parallel word to serialize.
- din_valid  in  1  din holds a valid word.
- din_ready  out  1  block can accept a word this cycle; a transfer happens when din_valid && din_ready at a rising edge.
- x  out  1  serial data bit to the downstream detector.
- x_valid  out  1  x carries a frame bit this cycle.
- busy  out  1  a frame is in progress (state != S_IDLE).
- done  out  1  high during the cycle in which the last bit of the frame is on x.

Behaviour:
- Reset values: state=S_IDLE, shift register=0, bit counter=0, x=0, x_valid=0, busy=0, done=0, din_ready=1.
- No transfer takes effect while rst=0. Reset mid-frame discards the word immediately; no partial-frame completion.
- States:
  - S_IDLE: x=0, x_valid=0, din_ready=1. On transfer: load din into the shift register, cnt=0, go to S_SHIFT.
  - S_SHIFT: x = current head bit, x_valid=1, busy=1. Each clock: shift by one (direction per MSB_FIRST), cnt++.
- Latency: a word accepted at edge k puts bit 0 of the frame on x at edge k; frame bit i is on x during the cycle after edge k+i.
- Last-bit cycle (cnt==WIDTH-1):
  - din_ready=1 and done=1.
  - If a transfer occurs: reload, cnt=0, stay in S_SHIFT. The next word's first bit follows with zero gap.
  - Otherwise: go to S_IDLE.
- din_ready = (state==S_IDLE) || last-bit cycle; it is combinational from state/cnt only, never from din_valid.
- din_valid asserted while not ready: ignored. din may change freely; it is sampled only on a transfer.
- x, x_valid, busy and done are driven from registers/state only, with no combinational path from din or din_valid.
- Counter width is $clog2(WIDTH+1). Wrap occurs only via reload or return to idle; cnt never exceeds the frame length minus 1.

Optional Feature:
- Macro: BIT_SERIALIZER_PARITY_EN.
- Defined:
  - After the WIDTH data bits, state S_PAR emits one even-parity bit (XOR of the word captured at transfer) with x_valid=1.
  - The frame is WIDTH+1 bits.
  - din_ready and done move from the last data bit to the S_PAR cycle; a back-to-back reload from S_PAR goes directly to S_SHIFT.
- Undefined: S_PAR and the parity register are absent; frame is WIDTH bits as above.

Decomposition:
- Package serializer_pkg holds:
  - state enum S_IDLE/S_SHIFT/S_PAR, with S_PAR present only under the macro;
  - the counter-width helper function.
- Single module; no sub-module is natural, since shift register, counter and FSM are tightly coupled.

Test Plan:
- WIDTH=8, MSB_FIRST=1, single transfer of 8'hB5 → x=1,0,1,1,0,1,0,1 on consecutive cycles with x_valid=1; done high on cycle 8 only; then x=0, x_valid=0, din_ready=1.
- MSB_FIRST=0, word 8'hB5 → x=1,0,1,0,1,1,0,1.
- Back-to-back 8'hB4 then 8'h5A with din_valid held high → 16 contiguous x_valid cycles 10110100_01011010; din_ready high only in cycles 8 and 16 plus idle.
- din_valid held high with 8'hFF during the busy cycles of a frame → no capture until the last-bit cycle; the frame in flight is unchanged.
- rst pulsed low at frame bit 3 → x=0, x_valid=0, busy=0, done=0 immediately; after release, 8'h2D serializes cleanly from bit 0.
- BIT_SERIALIZER_PARITY_EN with 8'hB5 → 9-bit frame, 9th bit=1 (five ones), done on bit 9. With 8'h03, parity bit=0.

Source files
------------

// File: rtl/serializer_pkg.sv
// Shared types for the bit serializer: FSM state encoding and counter sizing.
// S_PAR exists only when BIT_SERIALIZER_PARITY_EN is defined.
package serializer_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1
`ifdef BIT_SERIALIZER_PARITY_EN
    ,
    S_PAR   = 2'd2
`endif
  } state_t;

  // Bit counter must hold WIDTH when the parity bit extends the frame.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/bit_serializer.sv
// Parallel-in/serial-out feeder for the 101101 detector; BIT_SERIALIZER_PARITY_EN appends an even-parity bit.
// Latency: word accepted at edge k has its first bit on x after edge k, one bit per clock after that.
// Backpressure: din_ready only in idle or the last-bit cycle, so back-to-back words stream with no gap.
module bit_serializer
  import serializer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             done
);

  localparam int             CW        = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST_DATA = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] sreg_shifted;
  logic [CW-1:0]    cnt;
  logic             fill;
  logic             last_cycle;
  logic             xfer;

`ifdef BIT_SERIALIZER_PARITY_EN
  logic par;

  // Feeding parity in behind the data lands it at the head exactly in S_PAR.
  assign fill       = par;
  assign last_cycle = (state == S_PAR);
`else
  assign fill       = 1'b0;
  assign last_cycle = (state == S_SHIFT) && (cnt == LAST_DATA);
`endif

  assign din_ready = (state == S_IDLE) || last_cycle;
  assign xfer      = din_valid && din_ready;

  generate
    if (MSB_FIRST) begin : g_msb
      assign sreg_shifted = {sreg[WIDTH-2:0], fill};
      assign x            = sreg[WIDTH-1];
    end else begin : g_lsb
      assign sreg_shifted = {fill, sreg[WIDTH-1:1]};
      assign x            = sreg[0];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      sreg    <= '0;
      cnt     <= '0;
      x_valid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
      par     <= 1'b0;
`endif
    end else if (xfer) begin
      // Reload path serves both idle start and zero-gap back-to-back frames.
      state   <= S_SHIFT;
      sreg    <= din;
      cnt     <= '0;
      x_valid <= 1'b1;
      busy    <= 1'b1;
      done    <= 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
      par     <= ^din;
`endif
    end else begin
      case (state)
        S_SHIFT: begin
          if (cnt == LAST_DATA) begin
`ifdef BIT_SERIALIZER_PARITY_EN
            state <= S_PAR;
            sreg  <= sreg_shifted;
            cnt   <= cnt + CW'(1);
            done  <= 1'b1;
`else
            state   <= S_IDLE;
            sreg    <= '0;
            cnt     <= '0;
            x_valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
`endif
          end else begin
            sreg <= sreg_shifted;
            cnt  <= cnt + CW'(1);
`ifdef BIT_SERIALIZER_PARITY_EN
            done <= 1'b0;
`else
            done <= (cnt == LAST_DATA - CW'(1));
`endif
          end
        end
`ifdef BIT_SERIALIZER_PARITY_EN
        S_PAR: begin
          state   <= S_IDLE;
          sreg    <= '0;
          cnt     <= '0;
          x_valid <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
`endif
        default: begin
          state   <= S_IDLE;
          x_valid <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench: table-driven streaming checks on an MSB-first instance plus
// hand-written LSB-first, reset-mid-frame and parity sequences.
module tb_bit_serializer;

  localparam int W = 8;
`ifdef BIT_SERIALIZER_PARITY_EN
  localparam int F = W + 1;
`else
  localparam int F = W;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [W-1:0] m_din, l_din;
  logic m_vld, m_rdy, m_x, m_xv, m_busy, m_done;
  logic l_vld, l_rdy, l_x, l_xv, l_busy, l_done;

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .din(m_din), .din_valid(m_vld), .din_ready(m_rdy),
    .x(m_x), .x_valid(m_xv), .busy(m_busy), .done(m_done)
  );

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .din(l_din), .din_valid(l_vld), .din_ready(l_rdy),
    .x(l_x), .x_valid(l_xv), .busy(l_busy), .done(l_done)
  );

  typedef struct packed {
    logic [W-1:0] din;
    logic         vld;
    logic         x;
    logic         xv;
    logic         rdy;
    logic         busy;
    logic         done;
  } vec_t;

  vec_t tbl[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Frame bit i of word w; bits past the data are the even parity of w.
  function automatic logic frame_bit(input logic [W-1:0] w, input int i, input bit msb);
    if (i >= W) return ^w;
    return msb ? w[W-1-i] : w[i];
  endfunction

  // Each entry: inputs applied before an edge, outputs expected after it.
  task automatic add_frame(input logic [W-1:0] w, input bit hold);
    vec_t v;
    for (int i = 0; i < F; i++) begin
      v.din  = (i == 0) ? w : (hold ? 8'hFF : 8'h00);
      v.vld  = (i == 0) || hold;
      v.x    = frame_bit(w, i, 1'b1);
      v.xv   = 1'b1;
      v.busy = 1'b1;
      v.done = (i == F - 1);
      v.rdy  = (i == F - 1);
      tbl.push_back(v);
    end
  endtask

  task automatic add_idle();
    vec_t v;
    v = '{din: 8'h00, vld: 1'b0, x: 1'b0, xv: 1'b0, rdy: 1'b1, busy: 1'b0, done: 1'b0};
    tbl.push_back(v);
  endtask

  task automatic chk_idle_m(input string tag);
    chk({tag, ".x"}, m_x, 1'b0);
    chk({tag, ".x_valid"}, m_xv, 1'b0);
    chk({tag, ".busy"}, m_busy, 1'b0);
    chk({tag, ".done"}, m_done, 1'b0);
    chk({tag, ".din_ready"}, m_rdy, 1'b1);
  endtask

  initial begin
    m_din = '0; m_vld = 1'b0;
    l_din = '0; l_vld = 1'b0;
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk_idle_m("reset_msb");
    chk("reset_lsb.x_valid", l_xv, 1'b0);
    chk("reset_lsb.din_ready", l_rdy, 1'b1);
    rst = 1'b1;
    @(negedge clk);

    // Single frame, back-to-back pair with valid held (FF offered while busy), idle tail.
    add_frame(8'hB5, 1'b0);
    add_idle();
    add_frame(8'hB4, 1'b1);
    add_frame(8'h5A, 1'b1);
    add_idle();
    add_idle();

    foreach (tbl[k]) begin
      m_din = tbl[k].din;
      m_vld = tbl[k].vld;
      @(negedge clk);
      chk($sformatf("tbl[%0d].x", k), m_x, tbl[k].x);
      chk($sformatf("tbl[%0d].x_valid", k), m_xv, tbl[k].xv);
      chk($sformatf("tbl[%0d].din_ready", k), m_rdy, tbl[k].rdy);
      chk($sformatf("tbl[%0d].busy", k), m_busy, tbl[k].busy);
      chk($sformatf("tbl[%0d].done", k), m_done, tbl[k].done);
    end
    m_vld = 1'b0;

    // LSB-first instance: B5 -> 1,0,1,0,1,1,0,1 (then parity when enabled).
    l_din = 8'hB5; l_vld = 1'b1;
    @(negedge clk);
    l_din = 8'h00; l_vld = 1'b0;
    for (int i = 0; i < F; i++) begin
      chk($sformatf("lsb_b5[%0d].x", i), l_x, frame_bit(8'hB5, i, 1'b0));
      chk($sformatf("lsb_b5[%0d].x_valid", i), l_xv, 1'b1);
      chk($sformatf("lsb_b5[%0d].done", i), l_done, (i == F - 1));
      @(negedge clk);
    end
    chk("lsb_idle.x_valid", l_xv, 1'b0);
    chk("lsb_idle.din_ready", l_rdy, 1'b1);

    // Reset asserted while bit 3 of B5 is on x.
    m_din = 8'hB5; m_vld = 1'b1;
    @(negedge clk);
    m_vld = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst.x", m_x, 1'b1);
    chk("pre_rst.busy", m_busy, 1'b1);
    #2 rst = 1'b0;
    #1 chk_idle_m("mid_rst");
    m_din = 8'h2D; m_vld = 1'b1;
    @(negedge clk);
    chk("rst_held.x_valid", m_xv, 1'b0);
    chk("rst_held.busy", m_busy, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    m_vld = 1'b0; m_din = 8'h00;
    for (int i = 0; i < F; i++) begin
      chk($sformatf("post_rst_2d[%0d].x", i), m_x, frame_bit(8'h2D, i, 1'b1));
      chk($sformatf("post_rst_2d[%0d].x_valid", i), m_xv, 1'b1);
      chk($sformatf("post_rst_2d[%0d].done", i), m_done, (i == F - 1));
      @(negedge clk);
    end
    chk_idle_m("post_rst_idle");

`ifdef BIT_SERIALIZER_PARITY_EN
    // 8'h03 has two ones: parity bit must be 0, done on the ninth bit.
    m_din = 8'h03; m_vld = 1'b1;
    @(negedge clk);
    m_vld = 1'b0;
    repeat (W) @(negedge clk);
    chk("par03.x", m_x, 1'b0);
    chk("par03.x_valid", m_xv, 1'b1);
    chk("par03.done", m_done, 1'b1);
    chk("par03.din_ready", m_rdy, 1'b1);
    @(negedge clk);
    chk_idle_m("par03_idle");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
